// File: rtl/sr_latch_driver.sv
// Mod-N up/down counter that drives a bank of external clocked SR latches
// with one-cycle set/reset pulses and checks the latch readback.
module sr_latch_driver #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_err,
   input  logic [WIDTH-1:0] fb_q,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             mismatch,
   output logic [0:0]       dbg_state
);

   localparam logic [0:0]       INIT    = 1'b0;
   localparam logic [0:0]       RUN     = 1'b1;
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [0:0]       state;
   logic             chk_armed;
   logic [WIDTH-1:0] count_nxt;

   always_comb begin
      count_nxt = count;
      if (load) begin
         count_nxt = ({1'b0, load_val} < MOD_EXT) ? load_val : '0;
      end else if (en && up) begin
         count_nxt = (count == MAX_CNT) ? '0 : count + WIDTH'(1);
      end else if (en) begin
         count_nxt = (count == '0) ? MAX_CNT : count - WIDTH'(1);
      end
   end

   // The first RUN edge samples latches that were only just cleared, so the
   // readback check is armed one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         count     <= '0;
         s         <= '0;
         r         <= '0;
         mismatch  <= 1'b0;
         chk_armed <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               s         <= '0;
               r         <= '1;
               chk_armed <= 1'b0;
               state     <= RUN;
            end
            default: begin
               count     <= count_nxt;
               s         <= ~count & count_nxt;
               r         <= count & ~count_nxt;
               chk_armed <= 1'b1;
               state     <= RUN;
            end
         endcase

         // A fresh disagreement wins over a simultaneous clear.
         if (state == RUN && chk_armed && fb_q != count) begin
            mismatch <= 1'b1;
         end else if (clr_err) begin
            mismatch <= 1'b0;
         end
      end
   end

   assign tc = en && ((up && count == MAX_CNT) || (!up && count == '0));
   assign dbg_state = state;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver with an ideal clocked SR latch bank
// and a stuck-at-0 fault mask on the readback path.
module tb_sr_latch_driver;

   localparam int EW = 15;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_val;
   logic       clr_err;
   logic [3:0] fb_q;
   logic [3:0] s;
   logic [3:0] r;
   logic [3:0] count;
   logic       tc;
   logic       mismatch;
   logic [0:0] dbg_state;

   logic [3:0] lat_q;
   logic [3:0] fault_m;
   logic [EW-1:0] exp_q[$];
   int n_checks;
   int n_fail;

   sr_latch_driver #(.WIDTH(4), .MODULUS(10)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
      .load_val(load_val), .clr_err(clr_err), .fb_q(fb_q),
      .s(s), .r(r), .count(count), .tc(tc), .mismatch(mismatch),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ideal latch bank: captures s/r during the high phase
   initial lat_q = 4'b0110;
   always @(negedge clk) lat_q <= (lat_q & ~r) | s;
   assign fb_q = lat_q & ~fault_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: drive one cycle of inputs and push the post-edge expectation
   task automatic step(input logic e, input logic u, input logic l, input logic [3:0] lv,
                       input logic c, input logic [3:0] fm,
                       input logic [3:0] ec, input logic [3:0] es, input logic [3:0] er,
                       input logic etc, input logic emm, input logic est);
      en = e; up = u; load = l; load_val = lv; clr_err = c; fault_m = fm;
      exp_q.push_back({ec, es, er, etc, emm, est});
      @(negedge clk);
      #1;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [EW-1:0] x;
         x = exp_q.pop_front();
         chk("count", 32'(count), 32'(x[14:11]));
         chk("s", 32'(s), 32'(x[10:7]));
         chk("r", 32'(r), 32'(x[6:3]));
         chk("tc", 32'(tc), 32'(x[2]));
         chk("mismatch", 32'(mismatch), 32'(x[1]));
         chk("state", 32'(dbg_state), 32'(x[0]));
         chk("s_and_r", 32'(s & r), 32'(0));
      end
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      logic [3:0] o;
      logic [3:0] nw;
      n_checks = 0; n_fail = 0;
      en = 0; up = 0; load = 0; load_val = 0; clr_err = 0; fault_m = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #3;
      chk("rst_count", 32'(count), 0);
      chk("rst_s", 32'(s), 0);
      chk("rst_r", 32'(r), 0);
      chk("rst_mismatch", 32'(mismatch), 0);
      chk("rst_state", 32'(dbg_state), 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      // init pulse, then first RUN edge holding
      step(0, 0, 0, 0, 0, 0, 4'd0, 4'b0000, 4'b1111, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 4'd0, 4'b0000, 4'b0000, 0, 0, 1);

      // count up 0..9 then wrap
      for (int i = 1; i <= 9; i++) begin
         o = 4'(i - 1);
         nw = 4'(i);
         step(1, 1, 0, 0, 0, 0, nw, ~o & nw, o & ~nw, (i == 9), 0, 1);
      end
      step(1, 1, 0, 0, 0, 0, 4'd0, 4'b0000, 4'b1001, 0, 0, 1);

      // count down with wrap 0 -> 9
      step(1, 0, 0, 0, 0, 0, 4'd9, 4'b1001, 4'b0000, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 4'd8, 4'b0000, 4'b0001, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 4'd7, 4'b0111, 4'b1000, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 4'd6, 4'b0000, 4'b0001, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 4'd5, 4'b0001, 4'b0010, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 4'd4, 4'b0000, 4'b0001, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 4'd3, 4'b0011, 4'b0100, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 4'd2, 4'b0000, 4'b0001, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 4'd1, 4'b0001, 4'b0010, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 4'd0, 4'b0000, 4'b0001, 1, 0, 1);

      // loads: priority over en, out-of-range, equal value, boundary
      step(0, 1, 1, 4'd2,  0, 0, 4'd2, 4'b0010, 4'b0000, 0, 0, 1);
      step(1, 1, 1, 4'd7,  0, 0, 4'd7, 4'b0101, 4'b0000, 0, 0, 1);
      step(1, 1, 1, 4'd12, 0, 0, 4'd0, 4'b0000, 4'b0111, 0, 0, 1);
      step(1, 1, 1, 4'd0,  0, 0, 4'd0, 4'b0000, 4'b0000, 0, 0, 1);
      step(1, 1, 1, 4'd9,  0, 0, 4'd9, 4'b1001, 4'b0000, 1, 0, 1);
      step(0, 1, 1, 4'd0,  0, 0, 4'd0, 4'b0000, 4'b1001, 0, 0, 1);

      // readback mismatch: bit0 stuck at 0 while count = 1
      step(1, 1, 0, 0, 0, 4'b0001, 4'd1, 4'b0001, 4'b0000, 0, 0, 1);
      step(0, 1, 0, 0, 0, 4'b0001, 4'd1, 4'b0000, 4'b0000, 0, 1, 1);
      step(0, 1, 0, 0, 0, 4'b0001, 4'd1, 4'b0000, 4'b0000, 0, 1, 1);
      step(0, 1, 0, 0, 1, 4'b0000, 4'd1, 4'b0000, 4'b0000, 0, 0, 1);
      step(0, 1, 0, 0, 1, 4'b0001, 4'd1, 4'b0000, 4'b0000, 0, 1, 1);
      step(0, 1, 0, 0, 1, 4'b0000, 4'd1, 4'b0000, 4'b0000, 0, 0, 1);

      // reset mid-run at count 6, between edges
      step(0, 1, 1, 4'd6, 0, 0, 4'd6, 4'b0110, 4'b0001, 0, 0, 1);
      chk("pre_reset_count", 32'(count), 6);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_count", 32'(count), 0);
      chk("midrst_s", 32'(s), 0);
      chk("midrst_r", 32'(r), 0);
      chk("midrst_mismatch", 32'(mismatch), 0);
      chk("midrst_state", 32'(dbg_state), 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0, 4'd0, 4'b0000, 4'b1111, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0, 4'd1, 4'b0001, 4'b0000, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0, 4'd2, 4'b0010, 4'b0001, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 4'd2, 4'b0000, 4'b0000, 0, 0, 1);

      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Synchronous mod-N up/down counter that drives a bank of external clocked SR latches, one latch per count bit. It converts each state transition into one-cycle set/reset excitation pulses, then reads the latch outputs back to verify them. It sits between the counter control logic and the latch bank. The latch bank acts as the storage element; this block generates its excitation and checks the result.

## Interface
- WIDTH, 4: count and latch bank width.
- MODULUS, 10: count range 0..MODULUS-1; 2 <= MODULUS <= 2^WIDTH.
- clk  in  1  rising-edge clock; also gates the external latches.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- up  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load, priority over en.
- load_val  in  WIDTH  value to load.
- clr_err  in  1  clears the sticky mismatch flag.
- fb_q  in  WIDTH  latch bank q outputs, read back.
- s  out  WIDTH  set excitation, one bit per latch.
- r  out  WIDTH  reset excitation, one bit per latch.
- count  out  WIDTH  current count.
- tc  out  1  terminal count.
- mismatch  out  1  sticky flag: readback disagreed with count.

## Operation
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=INIT, count=0, s=0, r=0, mismatch=0.
- The FSM has two states, INIT and RUN.
- INIT state:
  - The first edge after rst_n rises registers r=all-ones and s=0, holding them for one cycle to clear every latch.
  - count holds 0; en and load are ignored; no readback check.
  - Next state is RUN.
- RUN next-count rules, in priority order:
  - load: load_val if load_val < MODULUS, else 0.
  - en & up: count+1, wrapping MODULUS-1 -> 0.
  - en & ~up: count-1, wrapping 0 -> MODULUS-1.
  - otherwise: hold.
- Excitation, registered on the same edge that updates count, per bit:
  - s = ~count_old & count_new.
  - r = count_old & ~count_new.
  - A hold gives s=r=0. s&r is never 1 on any bit.
- Readback check:
  - Compare fb_q against count on every edge taken in RUN, except the first RUN edge, which follows the INIT pulse cycle.
  - Set mismatch on any disagreement; it then stays 1.
- clr_err clears mismatch on the next edge. If a mismatch is detected on that same edge, set wins.
- tc = en & ((up & count==MODULUS-1) | (~up & count==0)). tc is combinational from registered count and the inputs.

## Timing
- count latency: one cycle from the en/load sample edge.
- s/r: a one-cycle pulse, valid in the same cycle the new count is visible.
  - The latches capture during the high phase of that cycle.
  - fb_q must equal count by the next rising edge, which is the edge where the check occurs.
- Continuous en gives back-to-back pulses; each cycle's s/r describes only that cycle's transition.
- The INIT clear pulse occupies exactly one cycle; first count change is possible on the second edge after reset release.
- Reset mid-operation: all outputs drop to reset values immediately (async). The INIT clear pulse is reissued after release.
- load=1 with en=0 still loads and pulses s/r.
- A load equal to the current count produces s=r=0.

## Test plan
- Reset and init: rst_n low then high.
  - During reset: count=0, s=0, r=0, mismatch=0.
  - First edge: r=4'b1111, s=0.
  - Second edge: r=0, state RUN.
- Up wrap, MODULUS=10, up=1, en=1, ideal latch model:
  - Count follows 0,1,...,9,0.
  - On 9->0 transition: s=0000, r=1001.
  - tc=1 while count=9; mismatch stays 0.
- Down wrap, up=0:
  - 0->9 gives s=1001, r=0000.
  - 3->2 gives s=0000, r=0001.
  - tc=1 while count=0.
- Load priority:
  - load=1, en=1, load_val=7 from count 2: count=7, s=0101, r=0000.
  - load_val=12: count=0.
  - load_val equal to count: s=r=0.
- Mismatch handling:
  - Force fb_q bit0 stuck at 0 while count=1: mismatch=1 on the check edge and remains set.
  - clr_err alone clears it.
  - clr_err on an edge with a new disagreement leaves mismatch=1.
- Reset mid-run:
  - Assert rst_n low at count=6 between edges: count=0, s=r=0 immediately.
  - After release, INIT pulse r=1111 occurs, then normal counting resumes.
